// File: rtl/lbist_stage_buffer.sv
// First-word-fall-through FIFO between PRPG and scan-load; a word written at edge N is visible right after edge N.
// Backpressure: in_ready drops only when full (no write-through), and out_data holds while out_ready is low.
module lbist_stage_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Status comes from the count register only, so no input reaches an output combinationally.
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = cnt;
    assign out_data  = mem[rp];

    assign push = in_valid & ~full;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    // Storage is not reset; a write in a reset/flush cycle is discarded along with the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wp] <= in_data;
    end
endmodule

// File: tb/tb_lbist_stage_buffer.sv
module tb_lbist_stage_buffer;
    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    int q[$];

    lbist_stage_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare DUT against the scoreboard, then advance the model.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy);
        bit mpush;
        bit mpop;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (chk_en) begin
            chk("count",     int'(count),     q.size());
            chk("empty",     int'(empty),     int'(q.size() == 0));
            chk("full",      int'(full),      int'(q.size() == 4));
            chk("in_ready",  int'(in_ready),  int'(q.size() < 4));
            chk("out_valid", int'(out_valid), int'(q.size() > 0));
            if (q.size() > 0)
                chk("out_data", int'(out_data), q[0]);
        end
        mpush = iv && (q.size() < 4);
        mpop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            if (mpop)  void'(q.pop_front());
            if (mpush) q.push_back(int'(d));
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        // Reset held two cycles with a write pending; nothing may be stored.
        cyc(1, 0, 1, 8'hAA, 0);
        chk_en = 1;
        cyc(1, 0, 1, 8'hAA, 0);
        cyc(0, 0, 0, 8'h00, 0);

        // Fill to full, reject a fifth word, then drain.
        cyc(0, 0, 1, 8'h11, 0);
        cyc(0, 0, 1, 8'h22, 0);
        cyc(0, 0, 1, 8'h33, 0);
        cyc(0, 0, 1, 8'h44, 0);
        cyc(0, 0, 1, 8'h55, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1);
        chk("drained_empty", int'(empty), 1);

        // Streaming across pointer wrap.
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(i), 1);
        chk("stream_count", int'(count), 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 8'h00, 1);

        // Full with simultaneous pop: push rejected, then push+pop accepted.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(8'hA0 + i), 0);
        cyc(0, 0, 1, 8'hB0, 1);
        chk("full_pop_count", int'(count), 3);
        cyc(0, 0, 1, 8'hB1, 1);
        chk("push_pop_count", int'(count), 3);
        cyc(0, 0, 0, 8'h00, 1);

        // Backpressure hold at count=2.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 0);
        chk("hold_count", int'(count), 2);

        // Flush mid-stream with push and pop requested.
        cyc(0, 0, 1, 8'hC0, 0);
        cyc(0, 1, 1, 8'hC1, 1);
        chk("flush_empty", int'(empty), 1);
        cyc(0, 0, 1, 8'h7E, 0);
        chk("after_flush_data", int'(out_data), 8'h7E);
        cyc(0, 0, 1, 8'h7F, 0);
        cyc(1, 1, 1, 8'hC2, 1);
        chk("rst_flush_count", int'(count), 0);
        cyc(0, 0, 0, 8'h00, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++)
            cyc(0, ($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1);
        chk("final_empty", int'(empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
